uart_buf_ctrl: RTL and testbench

Parametrised buffering and status layer between the UART serial engines (uart_rx / uart_tx) and the host-side register interface.
- Replaces the fixed 16-deep, flag-only FIFO glue.
- Adds configurable width and depth, fill-level reporting, programmable thresholds, RX character timeout, flush, a sticky overrun flag with clear, and interrupt outputs.

---
 rtl/uart_buf_pkg.sv | 26 ++
 rtl/uart_buf_ctrl_if.sv | 81 ++++++++
 rtl/uart_lvl_fifo.sv | 67 ++++++
 rtl/uart_buf_ctrl.sv | 165 ++++++++++++++++
 tb/tb_uart_buf_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_buf_pkg.sv
// uart_buf_pkg
//   Shared constants and types for the UART buffering layer.
//   - IRQ_* : bit positions inside the 4-bit interrupt source/enable vector
//             {overrun, timeout, tx_thresh, rx_thresh}.
//   - RX_*  : field layout of one RX FIFO entry {frame, parity, data}. The
//             flag offsets are relative to DATA_W because the character width
//             is a parameter of the block.
//   - irq_vec_t : the interrupt source/enable vector type.
package uart_buf_pkg;

    localparam int IRQ_RX_THR = 0;
    localparam int IRQ_TX_THR = 1;
    localparam int IRQ_TO     = 2;
    localparam int IRQ_OVR    = 3;
    localparam int IRQ_NUM    = 4;

    // RX entry: data in [DATA_W-1:0], parity at DATA_W+RX_PAR_REL,
    // frame at DATA_W+RX_FRM_REL.
    localparam int RX_DATA_LSB  = 0;
    localparam int RX_PAR_REL   = 0;
    localparam int RX_FRM_REL   = 1;
    localparam int RX_FLAG_BITS = 2;

    typedef logic [IRQ_NUM-1:0] irq_vec_t;

endpackage

// File: rtl/uart_buf_ctrl_if.sv
// uart_buf_ctrl_if
//   Bundles every non-clock/reset signal of uart_buf_ctrl: the RX/TX engine
//   handshakes, the host register-side push/pop and data, configuration
//   (thresholds, timeout, interrupt enables) and status/interrupt outputs.
//   Modports:
//     slave  - the buffer controller (drives o_* signals)
//     master - the surrounding engines/host (drives i_* signals)
//   With UART_RX_PEAK_EN defined the RX high-water mark o_rx_peak is added.
interface uart_buf_ctrl_if
    import uart_buf_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int TO_W   = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic              i_baud;
    logic              i_rx_wr;
    logic [DATA_W-1:0] i_rx_data;
    logic              i_rx_e_frame;
    logic              i_rx_e_parity;
    logic              o_rx_full;
    logic              i_tx_done;
    logic [DATA_W-1:0] o_tx_data;
    logic              o_tx_empty;
    logic              i_store;
    logic [DATA_W-1:0] i_trans_data;
    logic              i_load;
    logic [DATA_W-1:0] o_receive_data;
    logic              o_e_frame_flag;
    logic              o_e_parity_flag;
    logic              o_rx_data_avail;
    logic              o_tx_fifo_full;
    logic [LW-1:0]     o_rx_level;
    logic [LW-1:0]     o_tx_level;
    logic [LW-1:0]     i_rx_thresh;
    logic [LW-1:0]     i_tx_thresh;
    logic [TO_W-1:0]   i_timeout_value;
    logic              i_flush_rx;
    logic              i_flush_tx;
    logic              i_clr_overrun;
    irq_vec_t          i_irq_en;
    logic              o_e_overrun_flag;
    logic              o_irq_rx_thresh;
    logic              o_irq_tx_thresh;
    logic              o_irq_timeout;
    logic              o_irq;
`ifdef UART_RX_PEAK_EN
    logic [LW-1:0]     o_rx_peak;
`endif

    modport slave (
        input  i_baud, i_rx_wr, i_rx_data, i_rx_e_frame, i_rx_e_parity,
        input  i_tx_done, i_store, i_trans_data, i_load,
        input  i_rx_thresh, i_tx_thresh, i_timeout_value,
        input  i_flush_rx, i_flush_tx, i_clr_overrun, i_irq_en,
        output o_rx_full, o_tx_data, o_tx_empty, o_receive_data,
        output o_e_frame_flag, o_e_parity_flag, o_rx_data_avail, o_tx_fifo_full,
        output o_rx_level, o_tx_level, o_e_overrun_flag,
        output o_irq_rx_thresh, o_irq_tx_thresh, o_irq_timeout, o_irq
`ifdef UART_RX_PEAK_EN
        , output o_rx_peak
`endif
    );

    modport master (
        output i_baud, i_rx_wr, i_rx_data, i_rx_e_frame, i_rx_e_parity,
        output i_tx_done, i_store, i_trans_data, i_load,
        output i_rx_thresh, i_tx_thresh, i_timeout_value,
        output i_flush_rx, i_flush_tx, i_clr_overrun, i_irq_en,
        input  o_rx_full, o_tx_data, o_tx_empty, o_receive_data,
        input  o_e_frame_flag, o_e_parity_flag, o_rx_data_avail, o_tx_fifo_full,
        input  o_rx_level, o_tx_level, o_e_overrun_flag,
        input  o_irq_rx_thresh, o_irq_tx_thresh, o_irq_timeout, o_irq
`ifdef UART_RX_PEAK_EN
        , input o_rx_peak
`endif
    );

endinterface

// File: rtl/uart_lvl_fifo.sv
// uart_lvl_fifo
//   Show-ahead synchronous FIFO with fill-level output and flush.
//   Ports:
//     clk, rst : clock, synchronous active-high reset (pointers/level only)
//     flush    : discard contents; beats a push/pop in the same cycle
//     push, wdata : write request; dropped when full unless popping too
//     pop      : read request; ignored when empty
//     rdata    : head entry, combinational, 0 while empty
//     level    : entries held, 0..DEPTH
//     full, empty : level == DEPTH / level == 0
//   DEPTH must be a power of two so the pointers wrap by natural overflow.
module uart_lvl_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    // A push into a full FIFO still fits when the head leaves in the same
    // cycle; a pop from an empty FIFO never sees the same-cycle push.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage carries no reset; a flushed push must not land.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_buf_ctrl.sv
// uart_buf_ctrl
//   Buffering and status layer between uart_rx/uart_tx and the host
//   register interface: RX and TX level FIFOs, RX/TX threshold flags, RX
//   idle-character timeout, sticky RX overrun, and a registered combined
//   interrupt.
//   Ports:
//     i_clk : system clock
//     i_rst : synchronous active-high reset
//     bus   : uart_buf_ctrl_if.slave (engine handshakes, host push/pop,
//             configuration, status and interrupt outputs)
//   Build option: define UART_RX_PEAK_EN to add bus.o_rx_peak, the RX
//   high-water mark, cleared by reset or i_clr_overrun.
module uart_buf_ctrl
    import uart_buf_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int TO_W   = 16
) (
    input logic           i_clk,
    input logic           i_rst,
    uart_buf_ctrl_if.slave bus
);
    localparam int LW   = $clog2(DEPTH) + 1;
    localparam int RX_W = DATA_W + RX_FLAG_BITS;

    logic [RX_W-1:0]   rx_wdata;
    logic [RX_W-1:0]   rx_head;
    logic [LW-1:0]     rx_level;
    logic              rx_full;
    logic              rx_empty;
    logic [DATA_W-1:0] tx_head;
    logic [LW-1:0]     tx_level;
    logic              tx_full;
    logic              tx_empty;

    logic              ovr_p0;
    logic              rx_thr_p0;
    logic              tx_thr_p0;
    logic [TO_W-1:0]   to_cnt_p0;
    logic              to_flag_p0;
    logic              irq_p1;
    logic              rx_evt;
    logic              to_hit;
    irq_vec_t          irq_src;

    always_comb begin
        rx_wdata = '0;
        rx_wdata[RX_DATA_LSB +: DATA_W]   = bus.i_rx_data;
        rx_wdata[DATA_W + RX_PAR_REL]     = bus.i_rx_e_parity;
        rx_wdata[DATA_W + RX_FRM_REL]     = bus.i_rx_e_frame;
    end

    uart_lvl_fifo #(.WIDTH(RX_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .flush (bus.i_flush_rx),
        .push  (bus.i_rx_wr),
        .wdata (rx_wdata),
        .pop   (bus.i_load),
        .rdata (rx_head),
        .level (rx_level),
        .full  (rx_full),
        .empty (rx_empty)
    );

    uart_lvl_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .flush (bus.i_flush_tx),
        .push  (bus.i_store),
        .wdata (bus.i_trans_data),
        .pop   (bus.i_tx_done),
        .rdata (tx_head),
        .level (tx_level),
        .full  (tx_full),
        .empty (tx_empty)
    );

    assign bus.o_rx_full       = rx_full;
    assign bus.o_rx_level      = rx_level;
    assign bus.o_rx_data_avail = !rx_empty;
    assign bus.o_receive_data  = rx_head[RX_DATA_LSB +: DATA_W];
    assign bus.o_e_parity_flag = rx_head[DATA_W + RX_PAR_REL];
    assign bus.o_e_frame_flag  = rx_head[DATA_W + RX_FRM_REL];
    assign bus.o_tx_data       = tx_head;
    assign bus.o_tx_empty      = tx_empty;
    assign bus.o_tx_fifo_full  = tx_full;
    assign bus.o_tx_level      = tx_level;

    // ---- stage p0: status flags registered from current levels ----
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ovr_p0    <= 1'b0;
            rx_thr_p0 <= 1'b0;
            tx_thr_p0 <= 1'b0;
        end else begin
            // A character that arrives while full is lost unless the host
            // frees a slot in the same cycle; setting beats clearing.
            if (bus.i_rx_wr && rx_full && !bus.i_load)
                ovr_p0 <= 1'b1;
            else if (bus.i_clr_overrun)
                ovr_p0 <= 1'b0;
            rx_thr_p0 <= (bus.i_rx_thresh != '0) && (rx_level >= bus.i_rx_thresh);
            tx_thr_p0 <= (tx_level <= bus.i_tx_thresh);
        end
    end

    // Any RX activity restarts the idle interval; only buffered, untouched
    // characters can time out.
    assign rx_evt = bus.i_rx_wr || bus.i_load || bus.i_flush_rx;
    assign to_hit = (bus.i_timeout_value != '0) && (to_cnt_p0 == bus.i_timeout_value)
                    && !rx_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            to_cnt_p0  <= '0;
            to_flag_p0 <= 1'b0;
        end else begin
            if (rx_evt || rx_empty)
                to_cnt_p0 <= '0;
            else if (bus.i_baud && (to_cnt_p0 != '1))
                to_cnt_p0 <= to_cnt_p0 + TO_W'(1);
            if (rx_evt)
                to_flag_p0 <= 1'b0;
            else if (to_hit)
                to_flag_p0 <= 1'b1;
        end
    end

    assign bus.o_e_overrun_flag = ovr_p0;
    assign bus.o_irq_rx_thresh  = rx_thr_p0;
    assign bus.o_irq_tx_thresh  = tx_thr_p0;
    assign bus.o_irq_timeout    = to_flag_p0;

    always_comb begin
        irq_src             = '0;
        irq_src[IRQ_RX_THR] = rx_thr_p0;
        irq_src[IRQ_TX_THR] = tx_thr_p0;
        irq_src[IRQ_TO]     = to_flag_p0;
        irq_src[IRQ_OVR]    = ovr_p0;
    end

    // ---- stage p1: combined interrupt ----
    always_ff @(posedge i_clk) begin
        if (i_rst) irq_p1 <= 1'b0;
        else       irq_p1 <= |(irq_src & bus.i_irq_en);
    end

    assign bus.o_irq = irq_p1;

`ifdef UART_RX_PEAK_EN
    logic [LW-1:0] rx_peak_p0;

    always_ff @(posedge i_clk) begin
        if (i_rst || bus.i_clr_overrun)
            rx_peak_p0 <= '0;
        else if (rx_level > rx_peak_p0)
            rx_peak_p0 <= rx_level;
    end

    assign bus.o_rx_peak = rx_peak_p0;
`endif

endmodule

// File: tb/tb_uart_buf_ctrl.sv
module tb_uart_buf_ctrl;
    import uart_buf_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int TO_W   = 16;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [DATA_W+1:0] rxq [$];
    logic [DATA_W-1:0] txq [$];

    always #5 clk = ~clk;

    uart_buf_ctrl_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TO_W(TO_W)) bus ();

    uart_buf_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TO_W(TO_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_push(input logic [7:0] d, input logic fe, input logic pe, input bit keep);
        bus.i_rx_wr = 1'b1; bus.i_rx_data = d; bus.i_rx_e_frame = fe; bus.i_rx_e_parity = pe;
        if (keep) rxq.push_back({fe, pe, d});
        cyc();
        bus.i_rx_wr = 1'b0; bus.i_rx_e_frame = 1'b0; bus.i_rx_e_parity = 1'b0;
    endtask

    task automatic rx_pop();
        bus.i_load = 1'b1; cyc(); bus.i_load = 1'b0;
    endtask

    task automatic tx_store(input logic [7:0] d, input bit keep);
        bus.i_store = 1'b1; bus.i_trans_data = d;
        if (keep) txq.push_back(d);
        cyc();
        bus.i_store = 1'b0;
    endtask

    task automatic tx_pop();
        bus.i_tx_done = 1'b1; cyc(); bus.i_tx_done = 1'b0;
    endtask

    // Monitor: whenever a consumer pops a non-empty FIFO, the head must be
    // the oldest expected entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.i_load && bus.o_rx_data_avail) begin
                if (rxq.size() == 0) chk("rx_pop_unexpected", 32'(bus.o_receive_data), 32'hDEAD);
                else chk("rx_head", 32'({bus.o_e_frame_flag, bus.o_e_parity_flag, bus.o_receive_data}),
                         32'(rxq.pop_front()));
            end
            if (bus.i_tx_done && !bus.o_tx_empty) begin
                if (txq.size() == 0) chk("tx_pop_unexpected", 32'(bus.o_tx_data), 32'hDEAD);
                else chk("tx_head", 32'(bus.o_tx_data), 32'(txq.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.i_baud = 0; bus.i_rx_wr = 0; bus.i_rx_data = 0; bus.i_rx_e_frame = 0;
        bus.i_rx_e_parity = 0; bus.i_tx_done = 0; bus.i_store = 0; bus.i_trans_data = 0;
        bus.i_load = 0; bus.i_flush_rx = 0; bus.i_flush_tx = 0; bus.i_clr_overrun = 0;
        bus.i_rx_thresh = LW'(4); bus.i_tx_thresh = LW'(2);
        bus.i_timeout_value = TO_W'(32); bus.i_irq_en = 4'hF;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();

        // Reset in the middle of traffic
        for (int i = 0; i < 3; i++) begin
            bus.i_store = 1'b1; bus.i_trans_data = 8'hB0 + 8'(i);
            rx_push(8'hA0 + 8'(i), 1'b1, 1'b1, 1'b0);
        end
        bus.i_store = 1'b0;
        rst = 1'b1;
        cyc(); cyc();
        @(negedge clk);
        chk("rst_rx_level", 32'(bus.o_rx_level), 0);
        chk("rst_tx_level", 32'(bus.o_tx_level), 0);
        chk("rst_tx_empty", 32'(bus.o_tx_empty), 1);
        chk("rst_rx_avail", 32'(bus.o_rx_data_avail), 0);
        chk("rst_recv_data", 32'(bus.o_receive_data), 0);
        chk("rst_frame", 32'(bus.o_e_frame_flag), 0);
        chk("rst_tx_thr", 32'(bus.o_irq_tx_thresh), 0);
        chk("rst_irq", 32'(bus.o_irq), 0);
        chk("rst_overrun", 32'(bus.o_e_overrun_flag), 0);
        rst = 1'b0;
        bus.i_irq_en = 4'h0;
        cyc(); cyc();

        // RX fill to threshold, in-order pops with per-entry flags
        rx_push(8'h41, 1'b0, 1'b0, 1'b1);
        rx_push(8'h42, 1'b1, 1'b0, 1'b1);
        rx_push(8'h43, 1'b0, 1'b1, 1'b1);
        rx_push(8'h44, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("fill_level", 32'(bus.o_rx_level), 4);
        chk("fill_thr_early", 32'(bus.o_irq_rx_thresh), 0);
        chk("fill_head", 32'(bus.o_receive_data), 32'h41);
        cyc();
        @(negedge clk);
        chk("fill_thr", 32'(bus.o_irq_rx_thresh), 1);
        repeat (4) rx_pop();
        @(negedge clk);
        chk("drain_level", 32'(bus.o_rx_level), 0);
        chk("drain_avail", 32'(bus.o_rx_data_avail), 0);
        chk("drain_head_zero", 32'(bus.o_receive_data), 0);

        // Overrun
        bus.i_irq_en = 4'b1000;
        for (int i = 0; i < 16; i++) rx_push(8'h60 + 8'(i), 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("full_level", 32'(bus.o_rx_level), 16);
        chk("full_flag", 32'(bus.o_rx_full), 1);
        chk("full_no_ovr", 32'(bus.o_e_overrun_flag), 0);
        chk("full_no_irq", 32'(bus.o_irq), 0);
        rx_push(8'h55, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("ovr_level", 32'(bus.o_rx_level), 16);
        chk("ovr_set", 32'(bus.o_e_overrun_flag), 1);
        cyc();
        @(negedge clk);
        chk("ovr_irq", 32'(bus.o_irq), 1);
        bus.i_clr_overrun = 1'b1; cyc(); bus.i_clr_overrun = 1'b0;
        @(negedge clk);
        chk("ovr_clr", 32'(bus.o_e_overrun_flag), 0);
        bus.i_load = 1'b1;
        rx_push(8'h77, 1'b0, 1'b0, 1'b1);
        bus.i_load = 1'b0;
        @(negedge clk);
        chk("pushpop_full_level", 32'(bus.o_rx_level), 16);
        chk("pushpop_no_ovr", 32'(bus.o_e_overrun_flag), 0);
        bus.i_clr_overrun = 1'b1;
        rx_push(8'h88, 1'b0, 1'b0, 1'b0);
        bus.i_clr_overrun = 1'b0;
        @(negedge clk);
        chk("ovr_set_wins", 32'(bus.o_e_overrun_flag), 1);
        bus.i_clr_overrun = 1'b1; cyc(); bus.i_clr_overrun = 1'b0;
        repeat (16) rx_pop();
        @(negedge clk);
        chk("ovr_drain_level", 32'(bus.o_rx_level), 0);
        bus.i_irq_en = 4'b0100;

        // RX timeout
        rx_push(8'h5A, 1'b0, 1'b0, 1'b1);
        bus.i_baud = 1'b1; repeat (31) cyc(); bus.i_baud = 1'b0;
        cyc();
        @(negedge clk);
        chk("to_before", 32'(bus.o_irq_timeout), 0);
        chk("to_irq_before", 32'(bus.o_irq), 0);
        bus.i_baud = 1'b1; cyc(); bus.i_baud = 1'b0;
        cyc();
        @(negedge clk);
        chk("to_set", 32'(bus.o_irq_timeout), 1);
        cyc();
        @(negedge clk);
        chk("to_irq", 32'(bus.o_irq), 1);
        rx_pop();
        @(negedge clk);
        chk("to_clr_on_load", 32'(bus.o_irq_timeout), 0);
        bus.i_baud = 1'b1; repeat (40) cyc(); bus.i_baud = 1'b0;
        cyc();
        @(negedge clk);
        chk("to_empty_never", 32'(bus.o_irq_timeout), 0);
        bus.i_irq_en = 4'h0;

        // TX path
        @(negedge clk);
        chk("tx_thr_idle", 32'(bus.o_irq_tx_thresh), 1);
        tx_store(8'h10, 1'b1);
        tx_store(8'h20, 1'b1);
        tx_store(8'h30, 1'b1);
        @(negedge clk);
        chk("tx_level3", 32'(bus.o_tx_level), 3);
        chk("tx_head", 32'(bus.o_tx_data), 32'h10);
        chk("tx_not_empty", 32'(bus.o_tx_empty), 0);
        cyc();
        @(negedge clk);
        chk("tx_thr_above", 32'(bus.o_irq_tx_thresh), 0);
        tx_pop();
        cyc();
        @(negedge clk);
        chk("tx_level2", 32'(bus.o_tx_level), 2);
        chk("tx_thr_reach2", 32'(bus.o_irq_tx_thresh), 1);
        tx_pop();
        tx_pop();
        @(negedge clk);
        chk("tx_empty_end", 32'(bus.o_tx_empty), 1);
        chk("tx_head_zero", 32'(bus.o_tx_data), 0);
        tx_store(8'hC1, 1'b0);
        tx_store(8'hC2, 1'b0);
        bus.i_flush_tx = 1'b1;
        tx_store(8'hC3, 1'b0);
        bus.i_flush_tx = 1'b0;
        @(negedge clk);
        chk("tx_flush_level", 32'(bus.o_tx_level), 0);
        chk("tx_flush_empty", 32'(bus.o_tx_empty), 1);

        // Flush beats a same-cycle push
        bus.i_clr_overrun = 1'b1; cyc(); bus.i_clr_overrun = 1'b0;
        for (int i = 0; i < 5; i++) rx_push(8'h90 + 8'(i), 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_flush_level", 32'(bus.o_rx_level), 5);
        bus.i_flush_rx = 1'b1;
        rx_push(8'h99, 1'b0, 1'b0, 1'b0);
        bus.i_flush_rx = 1'b0;
        @(negedge clk);
        chk("flush_level", 32'(bus.o_rx_level), 0);
        chk("flush_avail", 32'(bus.o_rx_data_avail), 0);
        chk("flush_head_zero", 32'(bus.o_receive_data), 0);
        cyc();
`ifdef UART_RX_PEAK_EN
        @(negedge clk);
        chk("rx_peak", 32'(bus.o_rx_peak), 5);
`endif
        rx_pop();
        @(negedge clk);
        chk("pop_empty_ignored", 32'(bus.o_rx_level), 0);

        chk("rxq_consumed", 32'(rxq.size()), 0);
        chk("txq_consumed", 32'(txq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
